// File: rtl/a5_wb_pkg.sv
// Shared constants, FSM state type and byte-lane helper for the A5/1 Wishbone slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a5_wb_pkg;

    localparam int DATA_W = 32;

    // Byte offsets of the register map; decoding uses bits [4:2].
    localparam logic [4:0] OFF_KEY_LO = 5'h00;
    localparam logic [4:0] OFF_KEY_HI = 5'h04;
    localparam logic [4:0] OFF_FRAME  = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_DATA   = 5'h10;

    // CTRL register bit positions.
    localparam int CTRL_LOAD   = 0;
    localparam int CTRL_EMPTY  = 1;
    localparam int CTRL_FULL   = 2;
    localparam int CTRL_LOADED = 3;
    localparam int CTRL_IRQ_EN = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Replace only the bytes whose lane select is set.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [3:0]        sel
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/a5_wb_if.sv
// Wishbone classic 32-bit bus bundle between the SoC master and the A5/1 slave.
// Latency: n/a (wires only).
// Backpressure: slave holds off by delaying wb_ack_o / wb_err_o; master holds cyc/stb until then.
interface a5_wb_if;
    import a5_wb_pkg::*;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [4:0]        wb_adr_i;
    logic [3:0]        wb_sel_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/a5_wb_timeout.sv
// Wait counter bounding how long a DATA read may stall on an empty keystream FIFO.
// Latency: expired is combinational, high during the WAIT_LIMIT-th enabled cycle after clear.
// Backpressure: none; counter saturates at expiry.
// Ports: clk, reset (sync, active-high), clear (restart count), enable (count this cycle), expired.
module a5_wb_timeout #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(WAIT_LIMIT - 1);

    logic [15:0] cnt_q;

    // cnt_q counts wait cycles already spent; the current one is the last when it equals LAST.
    assign expired = enable && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/a5_wb_slave.sv
// Wishbone classic slave holding A5/1 key/frame, issuing load, and popping keystream words on DATA reads.
// Latency: ack one cycle after the request is sampled; empty-FIFO DATA reads ack the cycle after data arrives.
// Backpressure: DATA reads stall on ks_empty for up to WAIT_LIMIT cycles, then terminate with wb_err_o.
// Ports: clk, reset (sync, active-high); wb (a5_wb_if.slave); key/frame/load to generator;
//        ks_data/ks_empty/ks_full/ks_rd_en to the show-ahead keystream FIFO.
// Build option A5_WB_IRQ_EN: adds CTRL.irq_en and registered output irq = irq_en & !ks_empty.
module a5_wb_slave
    import a5_wb_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    a5_wb_if.slave            wb,
    output logic [63:0]       key,
    output logic [21:0]       frame,
    output logic              load,
    input  logic [DATA_W-1:0] ks_data,
    input  logic              ks_empty,
    input  logic              ks_full,
    output logic              ks_rd_en
`ifdef A5_WB_IRQ_EN
    ,
    output logic              irq
`endif
);

    state_t            state_q, state_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] rd_mux;
    logic              loaded;
    logic              req;
    logic [2:0]        word;
    logic              data_rd;
    logic              pop;
    logic              accept_reg;
    logic              zero_dat;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expired;
    logic              unused_adr;
`ifdef A5_WB_IRQ_EN
    logic              irq_en;
`endif

    assign unused_adr = &{1'b0, wb.wb_adr_i[1:0]};

    assign req     = wb.wb_cyc_i && wb.wb_stb_i;
    assign word    = wb.wb_adr_i[4:2];
    assign data_rd = (word == OFF_DATA[4:2]) && !wb.wb_we_i;

    a5_wb_timeout #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clr),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // Next state and per-cycle strobes. Everything is suppressed while reset is
    // asserted so a reset landing mid-transaction never pops the FIFO.
    always_comb begin
        state_d    = state_q;
        resp_err_d = resp_err_q;
        pop        = 1'b0;
        accept_reg = 1'b0;
        zero_dat   = 1'b0;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (!data_rd) begin
                            accept_reg = 1'b1;
                            resp_err_d = 1'b0;
                            state_d    = RESP;
                        end else if (!ks_empty) begin
                            pop        = 1'b1;
                            resp_err_d = 1'b0;
                            state_d    = RESP;
                        end else begin
                            tmo_clr = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        // Master abandoned the cycle: drop it silently.
                        state_d = IDLE;
                    end else if (!ks_empty) begin
                        pop        = 1'b1;
                        resp_err_d = 1'b0;
                        state_d    = RESP;
                    end else begin
                        tmo_en = 1'b1;
                        if (tmo_expired) begin
                            zero_dat   = 1'b1;
                            resp_err_d = 1'b1;
                            state_d    = RESP;
                        end
                    end
                end
                RESP: begin
                    // Never accept here: the master still shows stb for this edge.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Register read view, sampled on the accepting edge.
    always_comb begin
        rd_mux = '0;
        case (word)
            OFF_KEY_LO[4:2]: rd_mux = key[31:0];
            OFF_KEY_HI[4:2]: rd_mux = key[63:32];
            OFF_FRAME[4:2]:  rd_mux = {10'd0, frame};
            OFF_CTRL[4:2]: begin
                rd_mux[CTRL_EMPTY]  = ks_empty;
                rd_mux[CTRL_FULL]   = ks_full;
                rd_mux[CTRL_LOADED] = loaded;
`ifdef A5_WB_IRQ_EN
                rd_mux[CTRL_IRQ_EN] = irq_en;
`endif
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            resp_err_q <= 1'b0;
            dat_q      <= '0;
            key        <= '0;
            frame      <= '0;
            load       <= 1'b0;
            loaded     <= 1'b0;
`ifdef A5_WB_IRQ_EN
            irq_en     <= 1'b0;
            irq        <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            resp_err_q <= resp_err_d;
            load       <= 1'b0;
`ifdef A5_WB_IRQ_EN
            irq        <= irq_en && !ks_empty;
`endif
            if (pop) begin
                dat_q <= ks_data;
            end else if (zero_dat) begin
                dat_q <= '0;
            end else if (accept_reg) begin
                dat_q <= wb.wb_we_i ? '0 : rd_mux;
            end

            if (accept_reg && wb.wb_we_i) begin
                case (word)
                    OFF_KEY_LO[4:2]: key[31:0]  <= byte_merge(key[31:0], wb.wb_dat_i, wb.wb_sel_i);
                    OFF_KEY_HI[4:2]: key[63:32] <= byte_merge(key[63:32], wb.wb_dat_i, wb.wb_sel_i);
                    OFF_FRAME[4:2]:  frame <= 22'(byte_merge({10'd0, frame}, wb.wb_dat_i, wb.wb_sel_i));
                    OFF_CTRL[4:2]: begin
                        // load rises with the move to RESP, so it coincides with ack.
                        if (wb.wb_sel_i[0] && wb.wb_dat_i[CTRL_LOAD]) begin
                            load   <= 1'b1;
                            loaded <= 1'b1;
                        end
`ifdef A5_WB_IRQ_EN
                        if (wb.wb_sel_i[0]) begin
                            irq_en <= wb.wb_dat_i[CTRL_IRQ_EN];
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ks_rd_en    = pop;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = (state_q == RESP) && !resp_err_q;
    assign wb.wb_err_o = (state_q == RESP) && resp_err_q;

endmodule

// File: tb/tb_a5_wb_slave.sv
module tb_a5_wb_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] key, key2;
    logic [21:0] frame, frame2;
    logic        load, load2;
    logic [31:0] ks_data;
    logic        ks_empty, ks_full, ks_rd_en;
    logic        ks_rd_en2;
`ifdef A5_WB_IRQ_EN
    logic        irq, irq2;
`endif

    a5_wb_if bus ();
    a5_wb_if bus2 ();

    always #5 clk = ~clk;

    a5_wb_slave #(.WAIT_LIMIT(255)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb       (bus),
        .key      (key),
        .frame    (frame),
        .load     (load),
        .ks_data  (ks_data),
        .ks_empty (ks_empty),
        .ks_full  (ks_full),
        .ks_rd_en (ks_rd_en)
`ifdef A5_WB_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    // Second instance with a short timeout and a permanently empty FIFO.
    a5_wb_slave #(.WAIT_LIMIT(4)) dut_t (
        .clk      (clk),
        .reset    (reset),
        .wb       (bus2),
        .key      (key2),
        .frame    (frame2),
        .load     (load2),
        .ks_data  (32'h5A5A5A5A),
        .ks_empty (1'b1),
        .ks_full  (1'b0),
        .ks_rd_en (ks_rd_en2)
`ifdef A5_WB_IRQ_EN
        ,
        .irq      (irq2)
`endif
    );

    // Show-ahead FIFO model: pushes from the stimulus at negedge, pops on DUT request.
    logic [31:0] fmem [8];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr = '0;
    int          pops = 0;
    int          pops2 = 0;
    int          load_cycles = 0;
    int          cyc_cnt = 0;
    bit          bad_pop = 1'b0;

    assign ks_empty = (wr_ptr == rd_ptr);
    assign ks_full  = ((wr_ptr - rd_ptr) == 4'd8);
    assign ks_data  = fmem[rd_ptr[2:0]];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (load) load_cycles <= load_cycles + 1;
        if (ks_rd_en2) pops2 <= pops2 + 1;
        if (ks_rd_en) begin
            if (ks_empty) bad_pop <= 1'b1;
            else rd_ptr <= rd_ptr + 4'd1;
            pops <= pops + 1;
        end
    end

    task automatic push_now(input logic [31:0] d);
        fmem[wr_ptr[2:0]] = d;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One classic Wishbone transfer. lat = rising edges from request to the
    // first cycle where ack/err is visible; ack_cyc = cycle index at that point.
    task automatic xfer(input bit b2, input bit we, input logic [4:0] adr, input logic [3:0] sel,
                        input logic [31:0] wd, output logic [31:0] rd, output bit ack, output bit err,
                        output int lat, output bit ld, output int ack_cyc);
        @(negedge clk);
        if (b2) begin
            bus2.wb_cyc_i = 1'b1; bus2.wb_stb_i = 1'b1; bus2.wb_we_i = we;
            bus2.wb_adr_i = adr;  bus2.wb_sel_i = sel;  bus2.wb_dat_i = wd;
        end else begin
            bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
            bus.wb_adr_i = adr;  bus.wb_sel_i = sel;  bus.wb_dat_i = wd;
        end
        lat = 0; ack = 1'b0; err = 1'b0; ld = 1'b0; rd = '0;
        while (lat < 400) begin
            @(posedge clk); #1;
            lat++;
            ack = b2 ? bus2.wb_ack_o : bus.wb_ack_o;
            err = b2 ? bus2.wb_err_o : bus.wb_err_o;
            rd  = b2 ? bus2.wb_dat_o : bus.wb_dat_o;
            ld  = load;
            if (ack || err) break;
        end
        ack_cyc = cyc_cnt;
        chk("xfer_terminated", 64'(ack || err), 64'd1);
        @(posedge clk); #1;
        if (b2) begin bus2.wb_cyc_i = 1'b0; bus2.wb_stb_i = 1'b0; bus2.wb_we_i = 1'b0; end
        else begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; end
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic setv(input int i, input bit we, input logic [4:0] adr, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [31:0] exp, input string name);
        vecs[i].we = we; vecs[i].adr = adr; vecs[i].sel = sel;
        vecs[i].wd = wd; vecs[i].exp = exp; vecs[i].name = name;
    endtask

    logic [31:0] rd;
    bit          ack, err, ld, saw_resp;
    int          lat, ack_cyc, push_cyc, p0;

    initial begin
        for (int i = 0; i < 8; i++) fmem[i] = '0;
        wr_ptr = '0;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
        bus2.wb_cyc_i = 0; bus2.wb_stb_i = 0; bus2.wb_we_i = 0; bus2.wb_adr_i = '0; bus2.wb_sel_i = '0; bus2.wb_dat_i = '0;

        setv(0,  1, 5'h00, 4'hF, 32'h12345678, 32'h0,        "wr_key_lo");
        setv(1,  1, 5'h04, 4'hF, 32'h9ABCDEF0, 32'h0,        "wr_key_hi");
        setv(2,  0, 5'h00, 4'hF, 32'h0,        32'h12345678, "rd_key_lo");
        setv(3,  0, 5'h04, 4'hF, 32'h0,        32'h9ABCDEF0, "rd_key_hi");
        setv(4,  1, 5'h08, 4'hF, 32'hFFFFFFFF, 32'h0,        "wr_frame");
        setv(5,  0, 5'h08, 4'hF, 32'h0,        32'h003FFFFF, "rd_frame");
        setv(6,  1, 5'h00, 4'hF, 32'h00000000, 32'h0,        "clr_key_lo");
        setv(7,  1, 5'h00, 4'b0010, 32'hAABBCCDD, 32'h0,     "wr_key_lo_lane1");
        setv(8,  0, 5'h00, 4'hF, 32'h0,        32'h0000CC00, "rd_key_lo_lane1");
        setv(9,  0, 5'h14, 4'hF, 32'h0,        32'h0,        "rd_unmapped14");
        setv(10, 1, 5'h18, 4'hF, 32'hFFFFFFFF, 32'h0,        "wr_unmapped18");
        setv(11, 0, 5'h18, 4'hF, 32'h0,        32'h0,        "rd_unmapped18");
        setv(12, 0, 5'h0C, 4'hF, 32'h0,        32'h00000002, "rd_ctrl_empty");
        setv(13, 1, 5'h08, 4'b0001, 32'h000000AB, 32'h0,     "wr_frame_lane0");

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   64'(bus.wb_ack_o), 64'd0);
        chk("rst_err",   64'(bus.wb_err_o), 64'd0);
        chk("rst_dat",   64'(bus.wb_dat_o), 64'd0);
        chk("rst_key",   key, 64'd0);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_load",  64'(load), 64'd0);
        chk("rst_rd_en", 64'(ks_rd_en), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Register map vectors
        for (int i = 0; i < NV; i++) begin
            xfer(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wd, rd, ack, err, lat, ld, ack_cyc);
            chk({vecs[i].name, "_ack"}, 64'(ack), 64'd1);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'd1);
            if (!vecs[i].we) chk({vecs[i].name, "_dat"}, 64'(rd), 64'(vecs[i].exp));
        end
        chk("key_port",   key, 64'h9ABCDEF0_0000CC00);
        chk("frame_port", 64'(frame), 64'h3FFFAB);
        chk("no_load_yet", 64'(load_cycles), 64'd0);

        // Load strobe
        xfer(0, 1, 5'h0C, 4'hF, 32'h1, rd, ack, err, lat, ld, ack_cyc);
        chk("load_with_ack", 64'(ld), 64'd1);
        chk("load_lat", 64'(lat), 64'd1);
        xfer(0, 0, 5'h0C, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        chk("ctrl_loaded", 64'(rd), 64'h0000000A);
        xfer(0, 1, 5'h04, 4'hF, 32'h11223344, rd, ack, err, lat, ld, ack_cyc);
        chk("load_one_cycle", 64'(load_cycles), 64'd1);
        chk("key_hi_no_autoload", key, 64'h11223344_0000CC00);

        // DATA read with a word already present
        @(negedge clk); push_now(32'hDEADBEEF);
        p0 = pops;
        xfer(0, 0, 5'h10, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        chk("data_full_dat", 64'(rd), 64'hDEADBEEF);
        chk("data_full_lat", 64'(lat), 64'd1);
        chk("data_full_pops", 64'(pops - p0), 64'd1);

        // DATA read that waits for the FIFO to fill
        p0 = pops;
        fork
            begin
                repeat (10) @(negedge clk);
                push_cyc = cyc_cnt;
                push_now(32'hCAFEF00D);
            end
            xfer(0, 0, 5'h10, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        join
        chk("wait_fill_ack", 64'(ack), 64'd1);
        chk("wait_fill_cycle", 64'(ack_cyc), 64'(push_cyc + 1));
        chk("wait_fill_dat", 64'(rd), 64'hCAFEF00D);
        chk("wait_fill_pops", 64'(pops - p0), 64'd1);

        // Master abandons a waiting DATA read; a later word must not be consumed
        p0 = pops;
        saw_resp = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 5'h10;
        repeat (3) begin @(posedge clk); #1; saw_resp |= bus.wb_ack_o | bus.wb_err_o; end
        @(negedge clk);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        push_now(32'h0BADF00D);
        repeat (3) begin @(posedge clk); #1; saw_resp |= bus.wb_ack_o | bus.wb_err_o; end
        chk("abort_no_resp", 64'(saw_resp), 64'd0);
        chk("abort_no_pop", 64'(pops - p0), 64'd0);
        xfer(0, 0, 5'h10, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        chk("after_abort_dat", 64'(rd), 64'h0BADF00D);

        // Timeout on the short-limit instance
        xfer(1, 1, 5'h00, 4'hF, 32'h00000055, rd, ack, err, lat, ld, ack_cyc);
        xfer(1, 0, 5'h00, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        chk("t_key_lo", 64'(rd), 64'h55);
        xfer(1, 0, 5'h10, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        chk("t_err", 64'(err), 64'd1);
        chk("t_no_ack", 64'(ack), 64'd0);
        chk("t_lat", 64'(lat), 64'd5);
        chk("t_dat_zero", 64'(rd), 64'd0);
        chk("t_no_pop", 64'(pops2), 64'd0);

        // Reset while a DATA read is waiting
        p0 = pops;
        saw_resp = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 5'h10;
        repeat (3) begin @(posedge clk); #1; saw_resp |= bus.wb_ack_o | bus.wb_err_o; end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        saw_resp |= bus.wb_ack_o | bus.wb_err_o;
        chk("mid_rst_key", key, 64'd0);
        chk("mid_rst_frame", 64'(frame), 64'd0);
        @(negedge clk);
        reset = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; saw_resp |= bus.wb_ack_o | bus.wb_err_o; end
        chk("mid_rst_no_resp", 64'(saw_resp), 64'd0);
        chk("mid_rst_no_pop", 64'(pops - p0), 64'd0);
        xfer(0, 0, 5'h0C, 4'hF, 32'h0, rd, ack, err, lat, ld, ack_cyc);
        chk("mid_rst_ctrl", 64'(rd), 64'h00000002);

`ifdef A5_WB_IRQ_EN
        xfer(0, 1, 5'h0C, 4'hF, 32'h10, rd, ack, err, lat, ld, ack_cyc);
        chk("irq_idle", 64'(irq), 64'd0);
        @(negedge clk); push_now(32'h13572468);
        @(posedge clk); #1;
        chk("irq_set", 64'(irq), 64'd1);
`endif

        chk("never_pop_empty", 64'(bad_pop), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a5_wb_slave.md
Name: a5_wb_slave

Overview:
Wishbone classic 32-bit slave that fronts the A5/1 keystream buffer. It holds the key and frame registers and issues the one-cycle load strobe. It pops 32-bit keystream words from the buffer's show-ahead FIFO on reads of a DATA register. It sits directly downstream of the keystream buffer and upstream of the SoC bus.

Parameters:
WAIT_LIMIT, 255, max cycles a DATA read waits on an empty FIFO before terminating with wb_err_o (range 1..65535)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  5  byte address; bits [1:0] ignored
wb_sel_i  in  4  byte lane selects
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
key  out  64  key to generator
frame  out  22  frame number to generator
load  out  1  one-cycle (re)load strobe
ks_data  in  32  FIFO head word, valid when !ks_empty
ks_empty  in  1  FIFO empty
ks_full  in  1  FIFO full
ks_rd_en  out  1  FIFO pop

Behaviour:
- Register map:
  - 0x00 KEY_LO = key[31:0] (RW)
  - 0x04 KEY_HI = key[63:32] (RW)
  - 0x08 FRAME = frame in [21:0] (RW); [31:22] read 0, writes ignored
  - 0x0C CTRL:
    - W bit0 = load; reads 0
    - R bit1 = ks_empty
    - R bit2 = ks_full
    - R bit3 = loaded (sticky, set by load, cleared by reset)
    - bit4 = irq_en, see Optional Feature
  - 0x10 DATA (RO): read pops one word; writes are acked and ignored
  - 0x14-0x1C unmapped: ack, read 0, writes ignored
- Register writes honour wb_sel_i per byte.
- Reset values: all outputs 0; key=0, frame=0, loaded=0, FSM in IDLE.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: request = cyc&stb. Register access goes to RESP next cycle.
  - IDLE: DATA read with !ks_empty latches ks_data into wb_dat_o and pulses ks_rd_en in the same cycle, then goes to RESP.
  - IDLE: DATA read with ks_empty goes to WAIT and clears the wait counter.
  - WAIT: each cycle, if !ks_empty, latch, pop, then RESP (ack).
  - WAIT: else counter++; when counter reaches WAIT_LIMIT, wb_dat_o=0, then RESP with err.
  - WAIT: if cyc or stb drops, return to IDLE with no pop and no response.
  - RESP: exactly one of ack/err is high for one cycle, then IDLE. A request is never accepted in RESP, so there is no double-ack.
- Latency:
  - Register access: ack 1 cycle after the request is sampled.
  - DATA read with FIFO non-empty: ack 1 cycle after the request is sampled.
  - DATA read from empty: ack on the cycle after the word arrives.
- Write to CTRL with bit0=1: load=1 for exactly one cycle, coincident with ack; loaded set on the same edge. key and frame use their current register values.
- Key/frame writes do not auto-load.
- ks_rd_en is never asserted while ks_empty=1. It is asserted at most once per bus transaction.
- Reset mid-transaction: FSM to IDLE, no ack, ks_rd_en=0, all registers cleared.

Optional Feature:
A5_WB_IRQ_EN
- Defined:
  - Adds output port irq (1 bit), irq = irq_en & !ks_empty, registered with reset value 0.
  - CTRL bit4 (irq_en) is RW, reset 0.
- Undefined:
  - No irq port.
  - CTRL bit4 reads 0 and writes are ignored.

Decomposition:
- Package a5_wb_pkg:
  - register offset constants (KEY_LO..DATA)
  - CTRL bit index constants
  - FSM state typedef {IDLE, WAIT, RESP}
  - DATA_W = 32
- Sub-module a5_wb_timeout: the wait counter with WAIT_LIMIT, inputs clear/enable, output expired.
- Everything else inline.

Test Plan:
- Write KEY_LO=0x12345678 and KEY_HI=0x9ABCDEF0 with sel=4'hF, then read both back -> key=0x9ABCDEF012345678; each access acked 1 cycle after the request.
- Write FRAME=0xFFFFFFFF, then read -> 0x003FFFFF. Write KEY_LO=0xAABBCCDD with sel=4'b0010 over 0 -> 0x0000CC00.
- Write CTRL=0x1 -> load high for exactly one cycle with ack; CTRL read -> bit3=1; load stays low after a subsequent KEY write.
- FIFO model holding 0xDEADBEEF, read DATA -> wb_dat_o=0xDEADBEEF; ks_rd_en high exactly one cycle; ack next cycle.
- Read DATA from empty, FIFO fills after 10 cycles -> ack on the cycle after the word arrives, one pop. Repeat with WAIT_LIMIT=4 and no data -> wb_err_o after 4 wait cycles, wb_dat_o=0, no pop.
- Assert reset during WAIT -> no ack or err, key/frame=0; with A5_WB_IRQ_EN, set irq_en and make the FIFO non-empty -> irq=1 one cycle later.
